// File: rtl/mcu_multi_cycle_pkg.sv
// Shared opcode map, FSM state encoding and immediate helper for the multi-cycle MCU.
package mcu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_J    = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_OUT    = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Widest legal datapath is 32 bits; callers truncate to their own width.
    function automatic logic [31:0] sext4(input logic [3:0] imm);
        return {{28{imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/mcu_multi_cycle_regfile.sv
// 16 x DATA_W register file: two combinational read ports, one clocked write port, r0 tied to zero.
module mcu_regfile_param #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [16];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 4'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 4'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 4'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mcu_multi_cycle.sv
// Multi-cycle MCU core: one FSM sequences fetch/decode/execute/memory/writeback over
// req/ack instruction and data ports, plus a valid/ready output port and HALT.
//
//   state  | meaning
//   FETCH  | imem_req held until imem_ack, IR latched on ack
//   DECODE | rs/rt read into A/B, dispatch OUT/HALT
//   EXEC   | ALU result registered, branch/J/NOP retire here
//   MEM    | dmem_req held with stable addr/we/wdata until dmem_ack
//   WB     | register write, PC+1
//   OUT    | out_valid held until out_ready
//   HALT   | absorbing until clear
module mcu_multi_cycle
    import mcu_mc_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clear,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_r, b_r, alu_r, mdr;

    logic [3:0]        op, rs, rt, rd;
    logic [DATA_W-1:0] imm_d;
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] pc_plus1, br_target, j_target;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              is_alu, is_mem;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op = ir[15:12];
    assign rs = ir[11:8];
    assign rt = ir[7:4];
    assign rd = ir[3:0];

    assign imm_d = DATA_W'(sext4(ir[3:0]));
    assign imm_a = ADDR_W'(sext4(ir[3:0]));

    assign is_alu = (op <= OP_ADDI);
    assign is_mem = (op == OP_LW) || (op == OP_SW);

    assign pc_plus1  = pc_r + ADDR_W'(1);
    assign br_target = pc_plus1 + imm_a;
    // J keeps the 4K page of PC+1 and replaces the low 12 bits.
    assign j_target  = (pc_plus1 & ~ADDR_W'(16'h0FFF)) | ADDR_W'(ir[11:0]);

    always_comb begin
        alu_val = '0;
        case (op)
            OP_ADD:                alu_val = a_r + b_r;
            OP_SUB:                alu_val = a_r - b_r;
            OP_AND:                alu_val = a_r & b_r;
            OP_OR:                 alu_val = a_r | b_r;
            OP_XOR:                alu_val = a_r ^ b_r;
            OP_SLT:                alu_val = (a_r < b_r) ? DATA_W'(1) : '0;
            OP_ADDI, OP_LW, OP_SW: alu_val = a_r + imm_d;
            default:               alu_val = '0;
        endcase
    end

    assign rf_we    = (state == ST_WB);
    assign rf_waddr = ((op == OP_ADDI) || (op == OP_LW)) ? rt : rd;
    assign rf_wdata = (op == OP_LW) ? mdr : alu_r;

    mcu_regfile_param #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .clear   (clear),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .rdata_a (rf_a),
        .raddr_b (rt),
        .rdata_b (rf_b)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        out_valid  = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_FETCH: begin
                // Reset state is FETCH, so mask the request while clear is held.
                imem_req = !clear;
                if (imem_ack) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (op == OP_OUT)       state_next = ST_OUT;
                else if (op == OP_HALT) state_next = ST_HALT;
                else                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem)      state_next = ST_MEM;
                else if (is_alu) state_next = ST_WB;
                else             state_next = ST_FETCH;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (dmem_ack) state_next = (op == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: state_next = ST_FETCH;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pc_r  <= RESET_PC;
            ir    <= '0;
            a_r   <= '0;
            b_r   <= '0;
            alu_r <= '0;
            mdr   <= '0;
        end else begin
            case (state)
                ST_FETCH: if (imem_ack) ir <= imem_rdata;
                ST_DECODE: begin
                    a_r <= rf_a;
                    b_r <= rf_b;
                end
                ST_EXEC: begin
                    alu_r <= alu_val;
                    case (op)
                        OP_BEQ:  pc_r <= (a_r == b_r) ? br_target : pc_plus1;
                        OP_BNE:  pc_r <= (a_r != b_r) ? br_target : pc_plus1;
                        OP_J:    pc_r <= j_target;
                        default: if (!is_alu && !is_mem) pc_r <= pc_plus1;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LW) mdr <= dmem_rdata;
                        else             pc_r <= pc_plus1;
                    end
                end
                ST_WB:   pc_r <= pc_plus1;
                ST_OUT:  if (out_ready) pc_r <= pc_plus1;
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign dmem_addr  = ADDR_W'(alu_r);
    assign dmem_wdata = b_r;
    assign out_data   = a_r;

endmodule

// File: tb/tb_mcu_multi_cycle.sv
// Directed bench: a 16-bit core running an ALU/memory/branch/OUT program and an 8-bit core
// starting at 0xFFFE to exercise narrow data and PC wrap, plus HALT and clear mid-access.
module tb_mcu_multi_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear;

    logic        imem_req_a, imem_ack_a, dmem_req_a, dmem_we_a, dmem_ack_a;
    logic        out_valid_a, out_ready_a, halted_a;
    logic [15:0] imem_addr_a, imem_rdata_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
    logic [15:0] out_data_a, pc_a;

    logic        imem_req_b, imem_ack_b, dmem_req_b, dmem_we_b, dmem_ack_b;
    logic        out_valid_b, out_ready_b, halted_b;
    logic [15:0] imem_addr_b, imem_rdata_b, dmem_addr_b, pc_b;
    logic [7:0]  dmem_wdata_b, dmem_rdata_b, out_data_b;

    int n_checks = 0;
    int n_errors = 0;
    int phase = 0;
    int cyc = 0;
    int dwait = 0;
    int dmem_block = 0;
    int n_out_a = 0;
    int bp_cnt = 0;
    int bp_cycles = 0;
    int lw_cycles = 0;
    int serial_viol = 0;

    logic [15:0] dmem_a [16];
    logic [15:0] fa_addr [$];
    int          fa_cyc  [$];
    logic [15:0] outs_a  [$];
    logic [15:0] fb_addr [$];
    logic [7:0]  outs_b  [$];

    logic [15:0] exp_fa [27] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                                 16'h0006, 16'h0007, 16'h0008, 16'h000A, 16'h0009, 16'h0FFF,
                                 16'h1000, 16'h1FFE, 16'h1123, 16'h1124, 16'h1125, 16'h1126,
                                 16'h1127, 16'h1128, 16'h1129, 16'h112A, 16'h112B, 16'h112C,
                                 16'h112D, 16'h112E, 16'h112F};
    int          exp_gap [10] = '{4, 4, 4, 4, 8, 3, 7, 3, 3, 3};
    logic [15:0] exp_out [8]  = '{16'h0002, 16'h0002, 16'h0008, 16'h0001,
                                  16'hFFF8, 16'h0000, 16'hFFFD, 16'h0005};
    logic [15:0] exp_fb  [4]  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    function automatic logic [15:0] prog_a(input logic [15:0] addr);
        case (addr)
            16'h0000: return 16'h6015; // ADDI r1,r0,5
            16'h0001: return 16'h602D; // ADDI r2,r0,-3
            16'h0002: return 16'h0123; // ADD r3,r1,r2
            16'h0003: return 16'h8130; // SW r3,0(r1)
            16'h0004: return 16'h7140; // LW r4,0(r1)
            16'h0005: return 16'hC400; // OUT r4
            16'h0006: return 16'hC300; // OUT r3 (backpressured)
            16'h0007: return 16'hA113; // BNE r1,r1,+3
            16'h0008: return 16'hB00A; // J 0x00A
            16'h000A: return 16'h911E; // BEQ r1,r1,-2
            16'h0009: return 16'hBFFF; // J 0xFFF
            16'h0FFF: return 16'hD000; // NOP
            16'h1000: return 16'hBFFE; // J 0xFFE
            16'h1FFE: return 16'hB123; // J 0x123
            16'h1123: return 16'h1125; // SUB r5,r1,r2
            16'h1124: return 16'h5126; // SLT r6,r1,r2
            16'h1125: return 16'h4127; // XOR r7,r1,r2
            16'h1126: return 16'hC500;
            16'h1127: return 16'hC600;
            16'h1128: return 16'hC700;
            16'h1129: return 16'h6101; // ADDI r0,r1,1
            16'h112A: return 16'hC000;
            16'h112B: return 16'h3128; // OR r8,r1,r2
            16'h112C: return 16'h2129; // AND r9,r1,r2
            16'h112D: return 16'hC800;
            16'h112E: return 16'hC900;
            default:  return 16'hF000; // HALT
        endcase
    endfunction

    function automatic logic [15:0] prog_b(input logic [15:0] addr);
        case (addr)
            16'hFFFE: return 16'h601F; // ADDI r1,r0,-1
            16'hFFFF: return 16'h0111; // ADD r1,r1,r1
            16'h0000: return 16'hC100; // OUT r1
            default:  return 16'hF000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    assign imem_ack_a   = imem_req_a;
    assign imem_rdata_a = prog_a(imem_addr_a);
    assign dmem_ack_a   = dmem_req_a && (dmem_block == 0) && (dwait >= (dmem_we_a ? 0 : 3));
    assign dmem_rdata_a = dmem_a[dmem_addr_a[3:0]];
    assign out_ready_a  = (n_out_a != 1) || (bp_cnt >= 4);

    assign imem_ack_b   = imem_req_b;
    assign imem_rdata_b = prog_b(imem_addr_b);
    assign dmem_ack_b   = dmem_req_b;
    assign dmem_rdata_b = 8'h00;
    assign out_ready_b  = 1'b1;

    mcu_multi_cycle #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) u_dut_a (
        .clk(clk), .clear(clear),
        .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack_a), .imem_rdata(imem_rdata_a),
        .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_addr(dmem_addr_a), .dmem_wdata(dmem_wdata_a),
        .dmem_ack(dmem_ack_a), .dmem_rdata(dmem_rdata_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
        .halted(halted_a), .pc(pc_a)
    );

    mcu_multi_cycle #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'hFFFE)) u_dut_b (
        .clk(clk), .clear(clear),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b),
        .dmem_ack(dmem_ack_b), .dmem_rdata(dmem_rdata_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .halted(halted_b), .pc(pc_b)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        dwait <= (dmem_req_a && !dmem_ack_a) ? dwait + 1 : 0;
        if (dmem_req_a && dmem_ack_a && dmem_we_a) dmem_a[dmem_addr_a[3:0]] <= dmem_wdata_a;
        if (out_valid_a && out_ready_a) n_out_a <= n_out_a + 1;
        if (out_valid_a && !out_ready_a) bp_cnt <= bp_cnt + 1;
    end

    always @(negedge clk) begin
        if (phase == 1) begin
            if (imem_req_a && imem_ack_a) begin
                fa_addr.push_back(imem_addr_a);
                fa_cyc.push_back(cyc);
            end
            if (out_valid_a && out_ready_a) outs_a.push_back(out_data_a);
            if (out_valid_a && (n_out_a == 1)) begin
                bp_cycles++;
                chk("bp_out_data", out_data_a, 32'h2);
            end
            if (dmem_req_a) begin
                chk("dmem_addr", dmem_addr_a, 32'h5);
                if (!dmem_we_a) lw_cycles++;
                else if (dmem_ack_a) chk("sw_wdata", dmem_wdata_a, 32'h2);
            end
            if (dmem_req_a && imem_req_a) serial_viol++;
            if (imem_req_b && imem_ack_b) fb_addr.push_back(imem_addr_b);
            if (out_valid_b && out_ready_b) outs_b.push_back(out_data_b);
        end
    end

    initial begin
        int nf;
        clear = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req_a, 0);
        chk("rst_pc_a", pc_a, 32'h0);
        chk("rst_imem_addr_b", imem_addr_b, 32'hFFFE);
        chk("rst_outputs", {dmem_req_a, dmem_we_a, out_valid_a, halted_a, dmem_addr_a, out_data_a}, 0);

        phase = 1;
        clear = 1'b0;
        for (int i = 0; i < 3000 && !(halted_a && halted_b); i++) @(negedge clk);
        chk("halt_reached", {halted_a, halted_b}, 32'h3);
        nf = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req_a || imem_req_b) nf++;
        end
        chk("fetch_after_halt", nf, 0);
        phase = 2;

        chk("fetch_count_a", fa_addr.size(), 27);
        for (int i = 0; i < 27 && i < fa_addr.size(); i++) chk("fetch_addr_a", fa_addr[i], exp_fa[i]);
        for (int i = 0; i < 10 && i + 1 < fa_cyc.size(); i++)
            chk("fetch_gap_a", fa_cyc[i+1] - fa_cyc[i], exp_gap[i]);
        chk("out_count_a", outs_a.size(), 8);
        for (int i = 0; i < 8 && i < outs_a.size(); i++) chk("out_data_a", outs_a[i], exp_out[i]);
        chk("bp_valid_cycles", bp_cycles, 5);
        chk("lw_req_cycles", lw_cycles, 4);
        chk("serial_access", serial_viol, 0);
        chk("fetch_count_b", fb_addr.size(), 4);
        for (int i = 0; i < 4 && i < fb_addr.size(); i++) chk("fetch_addr_b", fb_addr[i], exp_fb[i]);
        chk("out_count_b", outs_b.size(), 1);
        if (outs_b.size() > 0) chk("out_data_b", outs_b[0], 32'hFE);

        // Restart with the data port stalled, then clear in the middle of the store.
        dmem_block = 1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 200 && !dmem_req_a; i++) @(negedge clk);
        chk("stall_dmem_req", dmem_req_a, 1);
        chk("stall_pc", pc_a, 32'h3);
        repeat (2) @(negedge clk);
        chk("stall_held_addr", dmem_addr_a, 32'h5);
        #2 clear = 1'b1;
        #1;
        chk("clr_dmem_req", dmem_req_a, 0);
        chk("clr_pc", pc_a, 32'h0);
        chk("clr_imem_req", imem_req_a, 0);
        chk("clr_dmem_addr", dmem_addr_a, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("restart_imem_req", imem_req_a, 1);
        chk("restart_imem_addr", imem_addr_a, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcu_multi_cycle.md
Name: mcu_multi_cycle

Overview:
- Parametrised multi-cycle successor to the single-cycle MCU.
- Keeps the 16-bit, 4-bit-opcode instruction format. Generalises datapath width (DATA_W) and address width (ADDR_W).
- Adds wait-state-tolerant req/ack instruction and data memory ports, a handshaked output port (feeds the LCD driver), and HALT.
- One FSM sequences fetch/decode/execute/memory/writeback.

Parameters:
- DATA_W, 16, register/ALU width; legal range 8..32.
- ADDR_W, 16, PC and memory address width; legal range 12..16.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete / load data valid.
- dmem_rdata  in  DATA_W  load data.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_W  value from OUT instruction.
- out_ready  in  1  consumer accepts out_data.
- halted  out  1  core is in HALT.
- pc  out  ADDR_W  current PC (debug).

Behaviour:
- Reset: clear is asynchronous and active-high, with one clock clk.
  - Reset values: PC=RESET_PC, all registers 0, state FETCH.
  - All outputs 0 except imem_addr=pc=RESET_PC.
  - Asserting clear mid-access drops req/valid immediately. Any in-flight access is abandoned.
- Instruction fields:
  - op=[15:12], rs=[11:8], rt=[7:4], rd=[3:0], imm4=[3:0].
  - imm4 is sign-extended to DATA_W.
  - r0 always reads 0; writes to r0 are discarded.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs op rt.
  - 5 SLT: rd = (rs <u rt) ? 1 : 0.
  - 6 ADDI: rt = rs + sext(imm4).
  - 7 LW: rt = mem[rs + sext(imm4)].
  - 8 SW: mem[rs + sext(imm4)] = rt.
  - 9 BEQ / A BNE: if the condition holds, PC = PC+1+sext(imm4) (mod 2^ADDR_W).
  - B J: PC = {PC+1[ADDR_W-1:12], instr[11:0]}.
  - C OUT: drive rs on the output port.
  - F HALT.
  - D, E: NOP.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W; no flags are kept. Memory address = ALU result[ADDR_W-1:0].
- FSM states: FETCH, DECODE, EXEC, MEM, WB, OUT, HALT.
  - FETCH: imem_req=1 and held until imem_ack. On ack, latch IR and go to DECODE. imem_ack may arrive in the same cycle as req.
  - DECODE: read rs/rt into A/B.
  - DECODE -> OUT for OUT; -> HALT for HALT; else -> EXEC.
  - EXEC: ALU result registered.
    - Branch/J/NOP: update PC, -> FETCH.
    - LW/SW -> MEM.
    - ALU ops -> WB.
  - MEM: dmem_req=1 with stable addr/we/wdata until dmem_ack.
    - LW: capture rdata, -> WB.
    - SW: PC+1, -> FETCH.
  - WB: write register, PC+1, -> FETCH.
  - OUT: out_valid=1 and out_data held until out_ready.
    - The transfer completes in the cycle valid&ready.
    - Then PC+1 and -> FETCH.
    - out_valid never drops before acceptance.
  - HALT: halted=1; absorbing until clear.
- Zero-wait latency: ALU/ADDI 4 cycles, LW 5, SW 4, branch/J/NOP 3, OUT 3 (if ready). Each wait cycle on ack/ready adds 1.
- PC wrap: PC+1 at 2^ADDR_W-1 wraps to 0.
- req and ack are never both pending on imem and dmem simultaneously (strictly serial).

Decomposition:
- Package mcu_mc_pkg holds:
  - opcode localparams;
  - FSM state encoding (3-bit);
  - the sign-extend function.
- Sub-module mcu_regfile_param(DATA_W): 16 x DATA_W, two asynchronous read ports, one synchronous write port, r0 forced to 0, async clear.

Test Plan:
- Reset/ALU: clear pulse; ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2; first imem_addr=RESET_PC; ADD retires 4 cycles after its fetch ack.
- Memory with wait states: SW r3,0(r1); LW r4,0(r1) with dmem_ack delayed 3 cycles -> dmem_addr=5, wdata=2; r4=2; req held stable throughout.
- Branch: BEQ r1,r1,-2 at PC=10 -> next fetch at 9; BNE r1,r1,+3 -> next fetch at PC+1; J 0x123 at PC=0x1FFE -> PC=0x1123.
- OUT backpressure: OUT r3 with out_ready low 4 cycles -> out_valid=1 and out_data=2 stable 5 cycles; next fetch 1 cycle after valid&ready.
- Width/wrap: DATA_W=8, ADDI r1,r0,-1 then ADD r1,r1,r1 -> 0xFE; PC at 0xFFFF (ADDR_W=16) increments to 0.
- HALT/reset mid-op: HALT -> halted=1 and no further imem_req; separately assert clear during an un-acked dmem_req -> dmem_req=0 immediately, PC=RESET_PC.
